// File: rtl/station_dispatch_if.sv
// station_dispatch_if: decoder-side push port and station-side broadcast/feed port of the dispatch queue
interface station_dispatch_if #(parameter int STATIONS = 4);
    logic                dec_valid;
    logic [31:0]         dec_iop;
    logic [2:0]          dec_iop_init;
    logic [15:0]         dec_pc;
    logic [15:0]         dec_k16;
    logic                dec_ready;
    logic                flush;
    logic [STATIONS-1:0] st_complete;
    logic [STATIONS-1:0] st_feed;
    logic [31:0]         st_iop;
    logic [2:0]          st_iop_init;
    logic [15:0]         st_pc;
    logic [15:0]         st_k16;
    logic [3:0]          q_count;
    modport master (
        output dec_valid, dec_iop, dec_iop_init, dec_pc, dec_k16, flush, st_complete,
        input  dec_ready, st_feed, st_iop, st_iop_init, st_pc, st_k16, q_count
    );
    modport slave (
        input  dec_valid, dec_iop, dec_iop_init, dec_pc, dec_k16, flush, st_complete,
        output dec_ready, st_feed, st_iop, st_iop_init, st_pc, st_k16, q_count
    );
endinterface

// File: rtl/station_dispatch.sv
// station_dispatch: decoded-iop FIFO that hands its head entry to the lowest-numbered idle reservation station
module station_dispatch #(
    parameter int DEPTH    = 4,
    parameter int STATIONS = 4
) (
    input logic clk,
    input logic a_rst,
    station_dispatch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   mem_iop  [DEPTH];
    logic [2:0]    mem_init [DEPTH];
    logic [15:0]   mem_pc   [DEPTH];
    logic [15:0]   mem_k16  [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [3:0]    count;
    logic          push;
    logic          pop;
    // Readiness comes from the registered count only, so a pop in the same cycle never frees a slot early
    assign bus.dec_ready = (count != 4'(DEPTH)) && !bus.flush;
    assign push = bus.dec_valid && bus.dec_ready;
    // Isolate the lowest idle station; the gate keeps an unknown st_complete off st_feed while empty
    assign bus.st_feed = (count != 4'd0 && !bus.flush) ? (bus.st_complete & (~bus.st_complete + STATIONS'(1))) : '0;
    assign pop = |bus.st_feed;
    assign bus.st_iop      = mem_iop[rptr];
    assign bus.st_iop_init = mem_init[rptr];
    assign bus.st_pc       = mem_pc[rptr];
    assign bus.st_k16      = mem_k16[rptr];
    assign bus.q_count     = count;
    // Queue state: pointers wrap naturally since DEPTH is a power of two; flush drops the queue but keeps storage
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_iop[i]  <= '0;
                mem_init[i] <= '0;
                mem_pc[i]   <= '0;
                mem_k16[i]  <= '0;
            end
        end else if (bus.flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem_iop[wptr]  <= bus.dec_iop;
                mem_init[wptr] <= bus.dec_iop_init;
                mem_pc[wptr]   <= bus.dec_pc;
                mem_k16[wptr]  <= bus.dec_k16;
                wptr           <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);
            if (push && !pop)
                count <= count + 4'd1;
            else if (pop && !push)
                count <= count - 4'd1;
        end
    end
endmodule

// File: tb/tb_station_dispatch.sv
// tb_station_dispatch: directed and random stimulus checked against a queue-based model of the dispatcher
module tb_station_dispatch;
    localparam int DEPTH = 4;
    localparam int STATIONS = 4;
    logic clk = 1'b0;
    logic a_rst = 1'b1;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [31:0] iop;
        logic [2:0]  init;
        logic [15:0] pc;
        logic [15:0] k16;
    } ent_t;
    ent_t q[$];
    always #5 clk = ~clk;
    station_dispatch_if #(.STATIONS(STATIONS)) bus ();
    station_dispatch #(.DEPTH(DEPTH), .STATIONS(STATIONS)) dut (.clk(clk), .a_rst(a_rst), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic drive(input logic v, input logic [31:0] iop, input logic [2:0] init,
                         input logic [15:0] pc, input logic [15:0] k16, input logic fl, input logic [3:0] sc);
        bus.dec_valid    = v;
        bus.dec_iop      = iop;
        bus.dec_iop_init = init;
        bus.dec_pc       = pc;
        bus.dec_k16      = k16;
        bus.flush        = fl;
        bus.st_complete  = sc;
    endtask
    function automatic logic [3:0] lowest(input logic [3:0] v);
        for (int i = 0; i < STATIONS; i++)
            if (v[i] === 1'b1) return 4'(1 << i);
        return 4'b0;
    endfunction
    task automatic tick();
        logic [3:0] ef;
        bit rdy;
        ent_t e;
        @(negedge clk);
        rdy = (q.size() != DEPTH) && !bus.flush;
        ef = (q.size() != 0 && !bus.flush) ? lowest(bus.st_complete) : 4'b0;
        chk("count", 32'(bus.q_count), q.size());
        chk("ready", 32'(bus.dec_ready), 32'(rdy));
        chk("feed", 32'(bus.st_feed), 32'(ef));
        if (q.size() != 0) begin
            chk("iop", bus.st_iop, q[0].iop);
            chk("init", 32'(bus.st_iop_init), 32'(q[0].init));
            chk("pc", 32'(bus.st_pc), 32'(q[0].pc));
            chk("k16", 32'(bus.st_k16), 32'(q[0].k16));
        end
        @(posedge clk);
        if (bus.flush) q.delete();
        else begin
            if (ef != 0) void'(q.pop_front());
            if (bus.dec_valid && rdy) begin
                e.iop = bus.dec_iop; e.init = bus.dec_iop_init; e.pc = bus.dec_pc; e.k16 = bus.dec_k16;
                q.push_back(e);
            end
        end
        #1;
    endtask
    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 32'(i), 3'(i), 16'(i * 3), 16'(i + 7), 1'b0, 4'b0000);
            tick();
        end
    endtask
    initial begin
        drive(1'b0, 32'h0, 3'h0, 16'h0, 16'h0, 1'b0, 4'b1111);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.q_count), 0);
        chk("rst_feed", 32'(bus.st_feed), 0);
        chk("rst_ready", 32'(bus.dec_ready), 1);
        chk("rst_iop", bus.st_iop, 0);
        chk("rst_init", 32'(bus.st_iop_init), 0);
        chk("rst_pc", 32'(bus.st_pc), 0);
        chk("rst_k16", 32'(bus.st_k16), 0);
        a_rst = 1'b0;
        drive(1'b1, 32'h0000_1234, 3'b101, 16'h0200, 16'h0010, 1'b0, 4'b0110);
        tick();
        drive(1'b0, 32'h0, 3'h0, 16'h0, 16'h0, 1'b0, 4'b0110);
        chk("single_feed", 32'(bus.st_feed), 32'h2);
        chk("single_iop", bus.st_iop, 32'h0000_1234);
        chk("single_count", 32'(bus.q_count), 1);
        tick();
        chk("single_drain", 32'(bus.q_count), 0);
        push_n(5, 32'hA0);
        chk("fill_count", 32'(bus.q_count), 4);
        chk("fill_ready", 32'(bus.dec_ready), 0);
        drive(1'b0, 32'h0, 3'h0, 16'h0, 16'h0, 1'b0, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            chk("fill_order", bus.st_iop, 32'hA0 + 32'(k));
            tick();
        end
        chk("fill_empty", 32'(bus.q_count), 0);
        push_n(2, 32'hB0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, $urandom, 3'($urandom), 16'($urandom), 16'($urandom), 1'b0, 4'b1000);
            tick();
            chk("conc_count", 32'(bus.q_count), 2);
        end
        push_n(1, 32'hC0);
        chk("pre_flush_count", 32'(bus.q_count), 3);
        drive(1'b1, 32'hDEAD, 3'h1, 16'h1, 16'h1, 1'b1, 4'b0001);
        chk("flush_feed", 32'(bus.st_feed), 0);
        tick();
        drive(1'b0, 32'h0, 3'h0, 16'h0, 16'h0, 1'b0, 4'b0001);
        chk("flush_count", 32'(bus.q_count), 0);
        chk("flush_nofeed", 32'(bus.st_feed), 0);
        tick();
        bus.st_complete = 4'bxxxx;
        #1;
        chk("x_gate", 32'(bus.st_feed), 0);
        push_n(2, 32'hE0);
        #2;
        bus.st_complete = 4'b1111;
        a_rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.q_count), 0);
        chk("arst_feed", 32'(bus.st_feed), 0);
        chk("arst_ready", 32'(bus.dec_ready), 1);
        a_rst = 1'b0;
        q.delete();
        repeat (3) tick();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 15) == 0, 4'($urandom & $urandom));
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/station_dispatch.md
STATION_DISPATCH -- requirements
Module: station_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, decoded-iop queue depth; legal values are powers of two, 2..8.
REQ-002 SHALL have parameter STATIONS, default 4, number of reservation stations served; legal values 1..8.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 a_rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 dec_valid  input  1  decoder offers an iop this cycle.
REQ-006 dec_iop  input  32  decoded internal operation word.
REQ-007 dec_iop_init  input  3  initial station state for the iop.
REQ-008 dec_pc  input  16  pc of the iop.
REQ-009 dec_k16  input  16  16-bit constant of the iop.
REQ-010 dec_ready  output  1  queue accepts a push this cycle.
REQ-011 flush  input  1  synchronous queue discard (branch redirect).
REQ-012 st_complete  input  STATIONS  per-station idle flag (station id_complete).
REQ-013 st_feed  output  STATIONS  one-hot load strobe (station id_feed).
REQ-014 st_iop / st_iop_init / st_pc / st_k16  output  32/3/16/16  broadcast head-entry fields shared by all stations.
REQ-015 q_count  output  4  current queue occupancy.

Function
REQ-016 SHALL hold a FIFO of DEPTH entries {iop, iop_init, pc, k16}, with write pointer, read pointer and occupancy count registers.
REQ-017 Push: dec_valid & dec_ready & ~flush at edge writes the entry at the write pointer; pointer wraps modulo DEPTH.
REQ-018 dec_ready SHALL equal (q_count != DEPTH) & ~flush; it is derived from registered count only and has no same-cycle pop credit.
REQ-019 Minimum latency SHALL be one cycle: an entry pushed at edge N appears on st_* outputs during cycle N+1; no decode-to-station bypass exists.
REQ-020 st_iop, st_iop_init, st_pc, st_k16 SHALL always show the entry at the read pointer, combinationally; contents are don't-care-but-stable when empty.
REQ-021 st_feed[i] SHALL be 1 for exactly the lowest index i with st_complete[i]=1, when q_count != 0 and flush=0; otherwise all zero.
REQ-022 Pop: any st_feed bit high at edge advances the read pointer (wrap modulo DEPTH); at most one pop per cycle.
REQ-023 Simultaneous push and pop SHALL leave q_count unchanged; push only increments it; pop only decrements it.
REQ-024 Stations load on the same edge as st_feed and drop st_complete the next cycle; the block SHALL NOT track per-station busy state or hold any extra guard.
REQ-025 An entry with iop_init 000 SHALL be dispatched like any other; the receiving station remains idle; no special case.
REQ-026 Order: iops SHALL leave in push order, and each is delivered to exactly one station exactly once.
REQ-027 flush=1 at edge SHALL zero both pointers and q_count, and SHALL suppress the push and the pop of that cycle; storage contents are not cleared.
REQ-028 With st_complete all zero, the queue SHALL hold its contents; when full, dec_ready=0 and dec_valid is ignored.
REQ-029 Any X on st_complete while q_count=0 SHALL NOT propagate to st_feed (gated to 0).

Reset
REQ-030 a_rst=1 SHALL immediately clear pointers, q_count and all storage to 0, regardless of clk.
REQ-031 During and after reset: st_feed=0, q_count=0, dec_ready=1 (when flush=0), and st_iop, st_iop_init, st_pc, st_k16 all 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; no st_feed pulse is issued for them after release.
REQ-033 The first push SHALL be accepted on the first rising edge after a_rst deasserts.

Verification
REQ-034 Single iop: push iop=0x0000_1234, init=101, pc=0x0200, k16=0x0010, st_complete=4'b0110 -> next cycle st_feed=4'b0010 with those fields; q_count 1->0.
REQ-035 Fill: push 5 iops back-to-back, st_complete=0 -> q_count=4, dec_ready=0, 5th dropped; then st_complete=4'b1111 for 4 cycles -> entries 1..4 dispatched in order; q_count=0.
REQ-036 Concurrent push/pop at q_count=2 with st_complete=4'b1000 -> st_feed=4'b1000, q_count stays 2; pointers wrap past DEPTH-1 correctly over 10 cycles.
REQ-037 Flush with q_count=3 and dec_valid=1 and st_complete=4'b0001 -> st_feed=0 that cycle; next cycle q_count=0, no entry dispatched.
REQ-038 Async reset pulse between clock edges with q_count=2 -> q_count=0, st_feed=0, dec_ready=1 immediately; no later dispatch of the old entries.
